// File: rtl/my_dmux_pkg.sv
// ---------------------------------------------------------------------------
// my_dmux_pkg
//   Shared definitions for the my_dmux_stream 1-to-N stream demultiplexer:
//   default geometry, the drop-counter saturation value and the per-channel
//   buffer occupancy encoding.
// ---------------------------------------------------------------------------
package my_dmux_pkg;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_CHANNELS = 4;

  // Saturation value of the out-of-range drop counter.
  localparam logic [7:0] DROP_MAX = 8'hFF;

  // Occupancy of one channel buffer. The single-entry build only uses
  // EMPTY and ONE.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

endpackage

// File: rtl/my_dmux_chan_buf.sv
// ---------------------------------------------------------------------------
// my_dmux_chan_buf
//   Output buffer for one demux channel. FIFO-ordered, one write port fed
//   by the demux, one valid/ready read port facing the channel's consumer.
//
//   Build option MY_DMUX_STREAM_SKID_EN:
//     defined   - two-entry buffer; wr_ready depends only on registered
//                 occupancy (no combinational path from rd_ready).
//     undefined - single-entry register; wr_ready = !rd_valid || rd_ready.
//
//   Ports
//     clk, rst_n  clock, asynchronous active-low reset
//     wr_en       write one beat this cycle (already qualified by wr_ready)
//     wr_data     beat to write
//     wr_ready    buffer can take a beat this cycle
//     rd_valid    buffer holds a beat (head presented on rd_data)
//     rd_data     head beat; holds its last value while rd_valid = 0
//     rd_ready    consumer takes the head beat
// ---------------------------------------------------------------------------
module my_dmux_chan_buf
  import my_dmux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ready,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  input  logic             rd_ready
);

  occ_e             occ_q, occ_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             drain;

  assign rd_valid = (occ_q != EMPTY);
  assign rd_data  = head_q;
  assign drain    = rd_valid && rd_ready;

`ifdef MY_DMUX_STREAM_SKID_EN

  logic [WIDTH-1:0] tail_q, tail_d;

  // Registered-state ready: a full buffer refuses even if the consumer is
  // draining this cycle, which breaks the rd_ready -> wr_ready path.
  assign wr_ready = (occ_q != TWO);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned (that would infer a latch).
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    case ({wr_en, drain})
      2'b10: begin
        if (occ_q == EMPTY) begin
          head_d = wr_data;
          occ_d  = ONE;
        end else begin
          tail_d = wr_data;
          occ_d  = TWO;
        end
      end
      2'b01: begin
        if (occ_q == TWO) begin
          head_d = tail_q;
          occ_d  = ONE;
        end else begin
          occ_d  = EMPTY;
        end
      end
      2'b11: begin
        // Accept and drain together: occupancy is unchanged and the new
        // beat lands behind whatever is still buffered.
        if (occ_q == TWO) begin
          head_d = tail_q;
          tail_d = wr_data;
        end else begin
          head_d = wr_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the data registers are reset too: they are a handful of
      // flops, not a RAM, and a defined out_data after reset is required.
      occ_q  <= EMPTY;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every
      // flop samples the pre-edge values of its neighbours.
      occ_q  <= occ_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

`else

  // Single register: refill is allowed in the cycle the old beat leaves.
  assign wr_ready = !rd_valid || rd_ready;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned (that would infer a latch).
    occ_d  = occ_q;
    head_d = head_q;
    if (wr_en) begin
      head_d = wr_data;
      occ_d  = ONE;
    end else if (drain) begin
      occ_d  = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the data register is reset too: it is a handful of flops,
      // not a RAM, and a defined out_data after reset is required.
      occ_q  <= EMPTY;
      head_q <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every
      // flop samples the pre-edge values of its neighbours.
      occ_q  <= occ_d;
      head_q <= head_d;
    end
  end

`endif

endmodule

// File: rtl/my_dmux_stream.sv
// ---------------------------------------------------------------------------
// my_dmux_stream
//   Registered 1-to-N stream demultiplexer with valid/ready handshaking.
//   Each input beat is routed to the channel named by sel; every channel
//   has its own buffer (my_dmux_chan_buf), so a stalled consumer only
//   blocks beats addressed to it. Beats with sel >= CHANNELS are accepted,
//   discarded and counted in a saturating 8-bit drop counter.
//
//   Build option MY_DMUX_STREAM_SKID_EN selects two-entry channel buffers
//   with registered ready; undefined gives single-entry pass-through ready.
//
//   Ports
//     clk, rst_n   clock, asynchronous active-low reset
//     in_data      input beat
//     sel          destination channel, sampled with in_data
//     in_valid     producer offers a beat
//     in_ready     beat can be accepted this cycle
//     out_data     channel c on bits [c*WIDTH +: WIDTH]
//     out_valid    channel c holds a beat
//     out_ready    consumer c takes the beat
//     drop_count   saturating count of beats dropped for out-of-range sel
// ---------------------------------------------------------------------------
module my_dmux_stream
  import my_dmux_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [WIDTH-1:0]          in_data,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [CHANNELS-1:0]       out_valid,
  input  logic [CHANNELS-1:0]       out_ready,
  output logic [7:0]                drop_count
);

  logic [CHANNELS-1:0] sel_hit;
  logic [CHANNELS-1:0] chan_ready;
  logic [CHANNELS-1:0] wr_en;
  logic                in_range;
  logic [7:0]          drop_q, drop_d;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    // One-hot decode; an out-of-range sel matches no channel.
    assign sel_hit[c] = (sel == SEL_W'(c));
    assign wr_en[c]   = in_valid && in_ready && sel_hit[c];

    my_dmux_chan_buf #(
      .WIDTH (WIDTH)
    ) u_buf (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (wr_en[c]),
      .wr_data  (in_data),
      .wr_ready (chan_ready[c]),
      .rd_valid (out_valid[c]),
      .rd_data  (out_data[c*WIDTH +: WIDTH]),
      .rd_ready (out_ready[c])
    );
  end

  assign in_range = |sel_hit;

  // Only the selected channel's readiness matters; dropped beats are
  // always accepted.
  assign in_ready = !in_range || (|(sel_hit & chan_ready));

  always_comb begin
    drop_d = drop_q;
    if (in_valid && !in_range && (drop_q != DROP_MAX)) begin
      drop_d = drop_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q <= '0;
    end else begin
      drop_q <= drop_d;
    end
  end

  assign drop_count = drop_q;

endmodule
